// File: rtl/sample_frame_packer.sv
// sample_frame_packer
//   Drains 12-bit samples from a show-ahead FIFO. Packs each sample pair
//   into three bytes and frames every SAMPLES_PER_FRAME samples as:
//   HDR0, HDR1, SEQ, payload, CHK. CHK is SEQ plus the payload bytes, mod 256.
//   Each byte goes out with a start/done handshake to the UART transmitter.
//   Optional build macro: PKT_LEN_FIELD_EN inserts a LEN byte
//   (SAMPLES_PER_FRAME[7:0]) after SEQ. The LEN byte is included in CHK.
module sample_frame_packer #(
    parameter int unsigned SAMPLES_PER_FRAME = 32,
    parameter logic [7:0]  HDR0              = 8'hA5,
    parameter logic [7:0]  HDR1              = 8'h5A
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        fifo_empty,
    input  logic [11:0] fifo_rd_data,
    output logic        fifo_rd_req,
    output logic [7:0]  tx_data,
    output logic        tx_start,
    input  logic        tx_done,
    output logic        frame_active,
    output logic [7:0]  seq_num
);

    localparam logic [7:0] PAIRS = 8'(SAMPLES_PER_FRAME / 2);
`ifdef PKT_LEN_FIELD_EN
    localparam logic [7:0] LEN_BYTE = 8'(SAMPLES_PER_FRAME);
`endif

    localparam logic [3:0] IDLE   = 4'd0;
    localparam logic [3:0] S_HDR0 = 4'd1;
    localparam logic [3:0] S_HDR1 = 4'd2;
    localparam logic [3:0] S_SEQ  = 4'd3;
`ifdef PKT_LEN_FIELD_EN
    localparam logic [3:0] S_LEN  = 4'd4;
`endif
    localparam logic [3:0] GET_A  = 4'd5;
    localparam logic [3:0] S_P0   = 4'd6;
    localparam logic [3:0] GET_B  = 4'd7;
    localparam logic [3:0] S_P1   = 4'd8;
    localparam logic [3:0] S_P2   = 4'd9;
    localparam logic [3:0] S_CHK  = 4'd10;
    localparam logic [3:0] WAIT   = 4'd11;

    logic [3:0]  state;
    logic [3:0]  ret_state;
    logic [11:0] a_smp;
    logic [11:0] b_smp;
    logic [7:0]  chk;
    logic [7:0]  pair_cnt;

    logic        is_send;
    logic [7:0]  send_byte;
    logic [7:0]  send_sum;
    logic [3:0]  send_ret;

    // Pop only from a fetch state with data present. Reset blocks the pop in the same cycle.
    always_comb begin
        fifo_rd_req = 1'b0;
        if (!rst && !fifo_empty && (state == GET_A || state == GET_B))
            fifo_rd_req = 1'b1;
    end

    // For each send state: decode the outgoing byte, the new checksum and the state to resume after tx_done.
    always_comb begin
        is_send   = 1'b1;
        send_byte = '0;
        send_sum  = chk;
        send_ret  = IDLE;
        case (state)
            S_HDR0: begin
                send_byte = HDR0;
                send_ret  = S_HDR1;
            end
            S_HDR1: begin
                send_byte = HDR1;
                send_ret  = S_SEQ;
            end
            S_SEQ: begin
                send_byte = seq_num;
                send_sum  = seq_num;
`ifdef PKT_LEN_FIELD_EN
                send_ret  = S_LEN;
`else
                send_ret  = GET_A;
`endif
            end
`ifdef PKT_LEN_FIELD_EN
            S_LEN: begin
                send_byte = LEN_BYTE;
                send_sum  = chk + LEN_BYTE;
                send_ret  = GET_A;
            end
`endif
            S_P0: begin
                send_byte = a_smp[11:4];
                send_sum  = chk + send_byte;
                send_ret  = GET_B;
            end
            S_P1: begin
                send_byte = {a_smp[3:0], b_smp[11:8]};
                send_sum  = chk + send_byte;
                send_ret  = S_P2;
            end
            S_P2: begin
                send_byte = b_smp[7:0];
                send_sum  = chk + send_byte;
                send_ret  = ((pair_cnt + 8'd1) < PAIRS) ? GET_A : S_CHK;
            end
            S_CHK: begin
                send_byte = chk;
                send_ret  = IDLE;
            end
            default: is_send = 1'b0;
        endcase
    end

    // Frame sequencer. A send state lasts one cycle and registers tx_start/tx_data,
    // then the shared WAIT state holds until tx_done and resumes at ret_state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            ret_state    <= IDLE;
            tx_start     <= 1'b0;
            tx_data      <= '0;
            frame_active <= 1'b0;
            seq_num      <= '0;
            chk          <= '0;
            pair_cnt     <= '0;
            a_smp        <= '0;
            b_smp        <= '0;
        end else begin
            tx_start <= 1'b0;
            if (is_send) begin
                tx_data   <= send_byte;
                tx_start  <= 1'b1;
                chk       <= send_sum;
                ret_state <= send_ret;
                state     <= WAIT;
                if (state == S_HDR0)
                    frame_active <= 1'b1;
                if (state == S_P2)
                    pair_cnt <= pair_cnt + 8'd1;
            end else begin
                case (state)
                    IDLE: begin
                        pair_cnt <= '0;
                        if (enable && !fifo_empty)
                            state <= S_HDR0;
                    end
                    GET_A: begin
                        if (!fifo_empty) begin
                            a_smp <= fifo_rd_data;
                            state <= S_P0;
                        end
                    end
                    GET_B: begin
                        if (!fifo_empty) begin
                            b_smp <= fifo_rd_data;
                            state <= S_P1;
                        end
                    end
                    WAIT: begin
                        if (tx_done) begin
                            state <= ret_state;
                            if (ret_state == IDLE) begin
                                frame_active <= 1'b0;
                                seq_num      <= seq_num + 8'd1;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sample_frame_packer.sv
// tb_sample_frame_packer
//   Directed sequence with random sample data. The bench computes each
//   expected frame from the list of pushed samples. Optional build macro:
//   PKT_LEN_FIELD_EN (the expected frames then include the LEN byte).
module tb_sample_frame_packer;

    localparam int SPF = 4;
    localparam logic [7:0] H0 = 8'hA5;
    localparam logic [7:0] H1 = 8'h5A;
`ifdef PKT_LEN_FIELD_EN
    localparam int LEN_N = 1;
`else
    localparam int LEN_N = 0;
`endif
    localparam int FLEN = 3 + LEN_N + (SPF * 3) / 2 + 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        fifo_empty;
    logic [11:0] fifo_rd_data;
    logic        fifo_rd_req;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_done = 1'b0;
    logic        frame_active;
    logic [7:0]  seq_num;

    always #10 clk = ~clk;

    sample_frame_packer #(
        .SAMPLES_PER_FRAME(SPF),
        .HDR0(H0),
        .HDR1(H1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .enable(enable),
        .fifo_empty(fifo_empty),
        .fifo_rd_data(fifo_rd_data),
        .fifo_rd_req(fifo_rd_req),
        .tx_data(tx_data),
        .tx_start(tx_start),
        .tx_done(tx_done),
        .frame_active(frame_active),
        .seq_num(seq_num)
    );

    // Show-ahead FIFO model
    logic [11:0] fifo_mem [0:4095];
    int unsigned wr_ptr = 0;
    int unsigned rd_ptr = 0;
    int unsigned pops = 0;
    int unsigned fifo_errs = 0;
    logic        prev_req = 1'b0;

    assign fifo_empty   = (rd_ptr == wr_ptr);
    assign fifo_rd_data = fifo_mem[rd_ptr[11:0]];

    always @(posedge clk) begin
        if (fifo_rd_req) begin
            if (rd_ptr == wr_ptr) fifo_errs++;
            if (prev_req) fifo_errs++;
            rd_ptr <= rd_ptr + 1;
            pops++;
        end
        prev_req = fifo_rd_req;
    end

    // UART model: logs each byte, returns tx_done done_delay cycles later, checks the handshake
    logic [7:0]  sent_q [$];
    int unsigned gap_q [$];
    int unsigned done_delay = 10;
    int unsigned uart_errs = 0;
    int unsigned ucyc = 0;
    int unsigned last_done = 0;
    int unsigned cnt = 0;
    logic        busy = 1'b0;
    logic        prev_start = 1'b0;
    logic [7:0]  held = '0;

    always @(posedge clk) begin
        ucyc++;
        tx_done <= 1'b0;
        if (rst) begin
            busy = 1'b0;
            cnt  = 0;
        end else if (tx_start) begin
            if (busy || prev_start) uart_errs++;
            sent_q.push_back(tx_data);
            gap_q.push_back(ucyc - last_done);
            busy = 1'b1;
            held = tx_data;
            cnt  = done_delay;
        end else if (busy) begin
            if (tx_data !== held) uart_errs++;
            cnt--;
            if (cnt == 0) begin
                tx_done <= 1'b1;
                busy = 1'b0;
                last_done = ucyc;
            end
        end
        prev_start = tx_start;
    end

    // Reference model state
    logic [11:0] mq [$];
    logic [7:0]  model_seq = 8'd0;
    int          rd_idx = 0;
    int unsigned n_total = 0;
    int unsigned n_pass = 0;
    int unsigned n_fail = 0;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_total++;
        assert (observed === expected) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic push_sample(input logic [11:0] s);
        fifo_mem[wr_ptr[11:0]] = s;
        wr_ptr = wr_ptr + 1;
        mq.push_back(s);
    endtask

    // Builds the next expected frame from the queued samples, waits for the DUT to send it, and compares.
    task automatic expect_frame(input string tag, input bit wait_idle, output int start);
        logic [7:0]  exp [$];
        logic [11:0] a;
        logic [11:0] b;
        logic [23:0] pair;
        int unsigned sum;
        int          budget;
        int          need;
        int          bad;
        exp.push_back(H0);
        exp.push_back(H1);
        exp.push_back(model_seq);
        sum = model_seq;
        if (LEN_N == 1) begin
            exp.push_back(8'(SPF));
            sum += SPF;
        end
        for (int p = 0; p < SPF / 2; p++) begin
            a = mq.pop_front();
            b = mq.pop_front();
            pair = {a, b};
            for (int k = 2; k >= 0; k--) begin
                exp.push_back(pair[8*k +: 8]);
                sum += pair[8*k +: 8];
            end
        end
        exp.push_back(8'(sum % 256));
        model_seq = model_seq + 8'd1;

        start  = rd_idx;
        need   = rd_idx + exp.size();
        budget = 0;
        while ((sent_q.size() < need || (wait_idle && frame_active)) && budget < 3000) begin
            @(negedge clk);
            budget++;
        end
        check({tag, " byte count"}, 32'(sent_q.size() >= need), 32'd1);
        if (sent_q.size() >= need) begin
            bad = exp.size() - 1;
            for (int i = exp.size() - 1; i >= 0; i--)
                if (sent_q[rd_idx + i] !== exp[i]) bad = i;
            check({tag, " bytes"}, sent_q[rd_idx + bad], exp[bad]);
        end
        rd_idx = need;
    endtask

    initial begin
        #4_000_000;
        $display("FAIL watchdog: simulation exceeded time limit, passed %0d of %0d", n_pass, n_total);
        $fatal(1, "watchdog");
    end

    initial begin
        int          st;
        int          st_arr [4];
        int unsigned p0;
        int unsigned consumed;
        int unsigned stall_bad;
        int          budget;
        int          base;
        logic [7:0]  lit [$];
        logic [7:0]  seq_before;

        // Reset values
        rst = 1'b1;
        enable = 1'b0;
        repeat (3) @(negedge clk);
        check("reset tx_start", tx_start, 0);
        check("reset tx_data", tx_data, 0);
        check("reset frame_active", frame_active, 0);
        check("reset seq_num", seq_num, 0);
        check("reset fifo_rd_req", fifo_rd_req, 0);
        rst = 1'b0;

        // Data is present but enable is low: nothing may start
        push_sample(12'hABC);
        push_sample(12'h123);
        push_sample(12'($urandom));
        push_sample(12'($urandom));
        repeat (20) @(negedge clk);
        check("disabled pops", pops, 0);
        check("disabled frame_active", frame_active, 0);

        // Basic frame; HDR0 start comes one cycle after the qualifying edge
        enable = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("hdr0 tx_start", tx_start, 1);
        check("hdr0 tx_data", tx_data, H0);
        check("hdr0 frame_active", frame_active, 1);
        expect_frame("basic frame", 1'b1, st);
        lit.push_back(8'hA5);
        lit.push_back(8'h5A);
        lit.push_back(8'h00);
        if (LEN_N == 1) lit.push_back(8'(SPF));
        lit.push_back(8'hAB);
        lit.push_back(8'hC1);
        lit.push_back(8'h23);
        for (int i = 0; i < lit.size(); i++)
            check("basic literal byte", sent_q[st + i], lit[i]);
        check("basic seq_num", seq_num, 1);
        check("basic pops", pops, SPF);

        // Back-to-back random frames: IDLE lasts one extra cycle versus a header-to-header gap
        done_delay = $urandom_range(2, 5);
        for (int i = 0; i < 4 * SPF; i++) push_sample(12'($urandom));
        for (int k = 0; k < 4; k++) expect_frame("random frame", (k == 3), st_arr[k]);
        for (int k = 1; k < 4; k++)
            check("b2b idle gap", gap_q[st_arr[k]], gap_q[st_arr[k] + 1] + 1);

        // Starvation: one sample only, the FSM must park in GET_B
        done_delay = 3;
        p0 = pops;
        push_sample(12'($urandom));
        base = rd_idx + 4 + LEN_N;
        budget = 0;
        while (sent_q.size() < base && budget < 500) begin
            @(negedge clk);
            budget++;
        end
        repeat (20) @(negedge clk);
        stall_bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (fifo_rd_req !== 1'b0 || tx_start !== 1'b0) stall_bad++;
        end
        check("starve stall activity", stall_bad, 0);
        check("starve bytes sent", sent_q.size() - rd_idx, 4 + LEN_N);
        check("starve pops", pops - p0, 1);
        for (int i = 0; i < SPF - 1; i++) push_sample(12'($urandom));
        expect_frame("starve frame", 1'b1, st);

        // Enable dropped mid-frame: the frame completes and no new frame starts
        p0 = pops;
        for (int i = 0; i < 2 * SPF; i++) push_sample(12'($urandom));
        repeat (10) @(negedge clk);
        check("drop mid-frame active", frame_active, 1);
        enable = 1'b0;
        expect_frame("enable drop frame", 1'b1, st);
        repeat (50) @(negedge clk);
        check("drop pops", pops - p0, SPF);
        check("drop frame_active", frame_active, 0);
        check("drop no new bytes", sent_q.size(), rd_idx);

        // Reset during payload, then a clean restart at sequence 0
        enable = 1'b1;
        p0 = pops;
        base = rd_idx + 5 + LEN_N;
        budget = 0;
        while (sent_q.size() < base && budget < 500) begin
            @(negedge clk);
            budget++;
        end
        rst = 1'b1;
        @(negedge clk);
        check("midreset tx_start", tx_start, 0);
        check("midreset frame_active", frame_active, 0);
        check("midreset seq_num", seq_num, 0);
        check("midreset fifo_rd_req", fifo_rd_req, 0);
        consumed = pops - p0;
        for (int i = 0; i < consumed; i++) mq.delete(0);
        rd_idx = sent_q.size();
        model_seq = 8'd0;
        for (int i = 0; i < consumed; i++) push_sample(12'($urandom));
        rst = 1'b0;
        expect_frame("post-reset frame", 1'b1, st);
        check("restart hdr0", sent_q[st], 8'hA5);
        check("restart seq byte", sent_q[st + 2], 8'h00);

        // 256 all-ones frames: the sequence wraps and CHK wraps
        done_delay = 2;
        for (int i = 0; i < 256 * SPF; i++) push_sample(12'hFFF);
        for (int k = 0; k < 256; k++) begin
            seq_before = model_seq;
            expect_frame("wrap frame", (k == 255), st);
            if (seq_before == 8'hFF || seq_before == 8'h00) begin
                check("wrap seq byte", sent_q[st + 2], seq_before);
                check("wrap chk", sent_q[st + FLEN - 1],
                      8'((seq_before + ((SPF * 3) / 2) * 255 + LEN_N * SPF) % 256));
            end
        end
        check("wrap seq_num", seq_num, model_seq);
        check("wrap fifo drained", fifo_empty, 1);

        check("fifo pop protocol", fifo_errs, 0);
        check("uart handshake protocol", uart_errs, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
